stage_ex_md: RTL and testbench
==============================

// Module: stage_ex_md
// PURPOSE
//  Parametrised RV32IM execute stage. Single-cycle logic/shift/arith/link/mem-address ops resolve combinationally.
//  Adds RV M-extension MUL/DIV via one shared iterative radix-2 datapath, stalling the pipeline until the result is ready.
//  Sits between the ID/EX and EX/MEM pipeline registers; stall_ex feeds the pipeline stall controller.
// PARAMETERS
//  XLEN        32  datapath width (power of 2, >=8)
//  REG_ADDR_W  5   register address width
//  EARLY_OUT   1   1: div-by-zero and signed overflow finish after 1 BUSY cycle; 0: full XLEN iterations
// PORTS
//  clk            in   1           clock, rising edge
//  reset          in   1           synchronous, active-high
//  flush          in   1           abort in-flight MUL/DIV; return to IDLE
//  hold_i         in   1           downstream (MEM) stall; EX/MEM not capturing this cycle
//  stall_ex       out  1           1 = EX result not ready; upstream holds inputs stable
//  alusel         in   3           001 logic, 010 shift, 100 arith, 110 link, 111 mem, 011 muldiv
//  aluop          in   3           op within alusel class
//  op1, op2       in   XLEN        operands
//  link_addr      in   XLEN        return address for JAL/JALR
//  mem_offset     in   XLEN        load/store offset
//  write_i        in   1           instruction writes rd
//  regw_addr_i    in   REG_ADDR_W  rd
//  write_o        out  1           write_i gated by result-valid
//  regw_addr_o    out  REG_ADDR_W  rd passthrough
//  regw_data      out  XLEN        result
//  load, store    out  1           memory op flags
//  mem_write_data out  XLEN        store data (= op2)
//  mem_length     out  3           1/2/4 bytes
//  mem_signed     out  1           sign-extend load
// BEHAVIOUR
//  Reset, synchronous and active-high, has priority over everything:
//  - state=IDLE, iteration count=0, operand/accumulator regs=0.
//  - All outputs 0 while reset=1.
//  Single-cycle classes: fully combinational, stall_ex=0. Every output has a default, so no latches.
//  - Logic ops: 0 OR, 1 AND, 2 XOR.
//  - Shift ops: 0 SLL, 1 SRL, 2 SRA, shift amount op2[$clog2(XLEN)-1:0].
//  - Arith ops: 0 ADD, 1 SUB, 2 SLT, 3 SLTU.
//  - Mem ops: regw_data = op1+mem_offset.
//    - aluop 0-4 = LB, LH, LW, LBU, LHU.
//    - aluop 5-7 = SB, SH, SW.
//  - Undefined aluop gives result 0.
//  muldiv ops (alusel=011): aluop 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
//  Each op uses FSM IDLE -> BUSY -> DONE:
//  - IDLE: on a muldiv op, stall_ex=1 combinationally in the same cycle (T). Latch |op1|, |op2|, result sign and op; count=0.
//  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; stall_ex=1. Exit to DONE when count=XLEN-1.
//  - DONE: apply sign fix-up. regw_data=result, write_o=write_i, stall_ex=0.
//    - Stay in DONE while hold_i=1, with result stable.
//    - Go to IDLE when hold_i=0 (EX/MEM captured).
//  Latency: stall_ex high for cycles T..T+XLEN; result valid from T+XLEN+1.
//  Early exits with EX early out (1 BUSY cycle), result valid at T+2:
//  - Div by zero: quotient all-ones; remainder = op1.
//  - Signed overflow (MIN / -1): quotient MIN; remainder 0.
//  - With EX early out = 0, these cases take full latency and give the same values.
//  Signed fix-up rules:
//  - Quotient negated if the operand signs differ.
//  - Remainder takes the sign of op1.
//  - MULH* return product[2*XLEN-1:XLEN]; MUL returns product[XLEN-1:0].
//  Passthrough: write_o=0 while stall_ex=1; regw_addr_o=regw_addr_i at all times.
//  flush=1 in any state: next state IDLE, count=0, no result is produced; stall_ex follows the combinational rule that cycle.
//  A new muldiv op arriving in the cycle after DONE->IDLE starts normally. Two identical back-to-back ops both execute.
// TESTING
//  1. ADD, alusel=100 aluop=0, op1=5 op2=7 -> regw_data=12, stall_ex=0 same cycle. SRA of 0x80000000 by 4 -> 0xF8000000.
//  2. DIV op1=-7 op2=2 -> stall_ex=1 for 33 cycles, then 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF.
//  3. DIVU op1=0x1234 op2=0, EARLY_OUT=1 -> result 0xFFFFFFFF at T+2. REMU op1=0x1234 op2=0 -> 0x1234.
//  4. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
//  5. MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 3*-4 -> 0xFFFFFFF4.
//  6. Mid-operation events on DIVU:
//     - flush at BUSY iteration 10 -> IDLE next cycle, no write_o.
//     - reset at the same point -> all outputs 0.
//     - hold_i=1 for 3 cycles in DONE -> regw_data stable, then one write_o.

Source files
------------

// File: rtl/stage_ex_md.sv
`default_nettype none
// ============================================================================
// Module      : stage_ex_md
// Description : RV32IM execute stage. Single-cycle ALU classes resolve
//               combinationally; MUL/DIV share one iterative radix-2 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_ex_md #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit EARLY_OUT  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  hold_i,
    output logic                  stall_ex,
    input  logic [2:0]            alusel,
    input  logic [2:0]            aluop,
    input  logic [XLEN-1:0]       op1,
    input  logic [XLEN-1:0]       op2,
    input  logic [XLEN-1:0]       link_addr,
    input  logic [XLEN-1:0]       mem_offset,
    input  logic                  write_i,
    input  logic [REG_ADDR_W-1:0] regw_addr_i,
    output logic                  write_o,
    output logic [REG_ADDR_W-1:0] regw_addr_o,
    output logic [XLEN-1:0]       regw_data,
    output logic                  load,
    output logic                  store,
    output logic [XLEN-1:0]       mem_write_data,
    output logic [2:0]            mem_length,
    output logic                  mem_signed
);

    localparam int              c_SHW  = $clog2(XLEN);
    localparam logic [c_SHW-1:0] c_LAST = c_SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_SEL_LOGIC = 3'b001;
    localparam logic [2:0] c_SEL_SHIFT = 3'b010;
    localparam logic [2:0] c_SEL_MD    = 3'b011;
    localparam logic [2:0] c_SEL_ARITH = 3'b100;
    localparam logic [2:0] c_SEL_LINK  = 3'b110;
    localparam logic [2:0] c_SEL_MEM   = 3'b111;

    logic [1:0]       r_state, w_state_nxt;
    logic [c_SHW-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi, r_lo, r_b, r_op1;
    logic [2:0]       r_op;
    logic             r_negq, r_negr, r_dz, r_ovf;

    logic             w_is_md, w_s1, w_s2, w_neg1, w_neg2;
    logic [XLEN-1:0]  w_abs1, w_abs2;
    logic [XLEN:0]    w_msum, w_drsh, w_ddiff;
    logic             w_dge;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]  w_quo, w_rem, w_md_res;
    logic [XLEN-1:0]  w_sc_data;
    logic             w_sc_load, w_sc_store, w_sc_signed;
    logic [2:0]       w_sc_len;
    logic [c_SHW-1:0] w_shamt;

    assign w_is_md = (alusel == c_SEL_MD);

    // Operand signedness: MUL/MULH/MULHSU treat op1 as signed, MUL/MULH op2; DIV/REM both.
    assign w_s1   = aluop[2] ? ~aluop[0] : (aluop[1:0] != 2'b11);
    assign w_s2   = aluop[2] ? ~aluop[0] : ~aluop[1];
    assign w_neg1 = w_s1 & op1[XLEN-1];
    assign w_neg2 = w_s2 & op2[XLEN-1];
    assign w_abs1 = w_neg1 ? -op1 : op1;
    assign w_abs2 = w_neg2 ? -op2 : op2;

    assign w_msum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
    assign w_drsh  = {r_hi, r_lo[XLEN-1]};
    assign w_ddiff = w_drsh - {1'b0, r_b};
    assign w_dge   = (w_drsh >= {1'b0, r_b});

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_negq ? -w_prod : w_prod;
    assign w_quo    = r_negq ? -r_lo : r_lo;
    assign w_rem    = r_negr ? -r_hi : r_hi;

    always_comb begin
        w_md_res = '0;
        case (r_op)
            3'd0:          w_md_res = w_prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_md_res = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    w_md_res = r_dz ? {XLEN{1'b1}} : (r_ovf ? c_MIN : w_quo);
            default:       w_md_res = r_dz ? r_op1 : (r_ovf ? {XLEN{1'b0}} : w_rem);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (!flush && w_is_md) w_state_nxt = c_BUSY;
            c_BUSY: begin
                if (flush) begin
                    w_state_nxt = c_IDLE;
                end else if ((EARLY_OUT && (r_dz || r_ovf)) || (r_cnt == c_LAST)) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: if (flush || !hold_i) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Shared radix-2 datapath: mul keeps {hi,lo} as product/multiplier, div as remainder/quotient.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_op1  <= '0;
            r_op   <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (r_state == c_IDLE && w_is_md) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= aluop[2] ? w_abs1 : w_abs2;
            r_b    <= aluop[2] ? w_abs2 : w_abs1;
            r_op1  <= op1;
            r_op   <= aluop;
            r_negq <= w_neg1 ^ w_neg2;
            r_negr <= w_neg1;
            r_dz   <= aluop[2] & (op2 == '0);
            r_ovf  <= aluop[2] & ~aluop[0] & (op1 == c_MIN) & (op2 == {XLEN{1'b1}});
        end else if (r_state == c_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op[2]) begin
                r_hi <= w_dge ? w_ddiff[XLEN-1:0] : w_drsh[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_dge};
            end else begin
                r_hi <= w_msum[XLEN:1];
                r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign w_shamt = op2[c_SHW-1:0];

    always_comb begin
        w_sc_data   = '0;
        w_sc_load   = 1'b0;
        w_sc_store  = 1'b0;
        w_sc_signed = 1'b0;
        w_sc_len    = 3'd0;
        case (alusel)
            c_SEL_LOGIC: case (aluop)
                3'd0:    w_sc_data = op1 | op2;
                3'd1:    w_sc_data = op1 & op2;
                3'd2:    w_sc_data = op1 ^ op2;
                default: w_sc_data = '0;
            endcase
            c_SEL_SHIFT: case (aluop)
                3'd0:    w_sc_data = op1 << w_shamt;
                3'd1:    w_sc_data = op1 >> w_shamt;
                3'd2:    w_sc_data = $signed(op1) >>> w_shamt;
                default: w_sc_data = '0;
            endcase
            c_SEL_ARITH: case (aluop)
                3'd0:    w_sc_data = op1 + op2;
                3'd1:    w_sc_data = op1 - op2;
                3'd2:    w_sc_data = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
                3'd3:    w_sc_data = {{(XLEN-1){1'b0}}, op1 < op2};
                default: w_sc_data = '0;
            endcase
            c_SEL_LINK: w_sc_data = link_addr;
            c_SEL_MEM: begin
                w_sc_data   = op1 + mem_offset;
                w_sc_load   = (aluop <= 3'd4);
                w_sc_store  = (aluop >= 3'd5);
                w_sc_signed = (aluop == 3'd0) || (aluop == 3'd1);
                case (aluop)
                    3'd0, 3'd3, 3'd5: w_sc_len = 3'd1;
                    3'd1, 3'd4, 3'd6: w_sc_len = 3'd2;
                    default:          w_sc_len = 3'd4;
                endcase
            end
            default: w_sc_data = '0;
        endcase
    end

    always_comb begin
        stall_ex       = 1'b0;
        write_o        = 1'b0;
        regw_addr_o    = '0;
        regw_data      = '0;
        load           = 1'b0;
        store          = 1'b0;
        mem_write_data = '0;
        mem_length     = 3'd0;
        mem_signed     = 1'b0;
        if (!reset) begin
            regw_addr_o = regw_addr_i;
            if (r_state == c_DONE) begin
                regw_data = w_md_res;
                write_o   = write_i & ~flush;
            end else if (r_state == c_BUSY || w_is_md) begin
                stall_ex = 1'b1;
            end else begin
                regw_data      = w_sc_data;
                write_o        = write_i;
                load           = w_sc_load;
                store          = w_sc_store;
                mem_write_data = w_sc_store ? op2 : '0;
                mem_length     = w_sc_len;
                mem_signed     = w_sc_signed;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_ex_md.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_ex_md
// Description : Directed, self-checking bench for the RV32IM execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stage_ex_md;

    logic        clk = 1'b0;
    logic        reset, flush, hold_i, write_i;
    logic [2:0]  alusel, aluop;
    logic [31:0] op1, op2, link_addr, mem_offset;
    logic [4:0]  regw_addr_i;
    logic        stall_ex, write_o, load, store, mem_signed;
    logic [4:0]  regw_addr_o;
    logic [31:0] regw_data, mem_write_data;
    logic [2:0]  mem_length;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stage_ex_md #(.XLEN(32), .REG_ADDR_W(5), .EARLY_OUT(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .hold_i(hold_i), .stall_ex(stall_ex),
        .alusel(alusel), .aluop(aluop), .op1(op1), .op2(op2), .link_addr(link_addr),
        .mem_offset(mem_offset), .write_i(write_i), .regw_addr_i(regw_addr_i),
        .write_o(write_o), .regw_addr_o(regw_addr_o), .regw_data(regw_data),
        .load(load), .store(store), .mem_write_data(mem_write_data),
        .mem_length(mem_length), .mem_signed(mem_signed)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  op;
        logic [31:0] a, b, link, off;
        logic [31:0] data, wdata;
        logic        ld, st, sg;
        logic [2:0]  len;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_md(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_cyc, input int hold_cyc);
        int cnt = 0;
        @(negedge clk);
        alusel = 3'b011; aluop = op; op1 = a; op2 = b; write_i = 1'b1; regw_addr_i = 5'd9;
        #1;
        chk({nm, " write_o while stalled"}, 64'(write_o), 64'd0);
        while (stall_ex && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk({nm, " stall cycles"}, 64'(cnt), 64'(exp_cyc));
        chk({nm, " result"}, 64'(regw_data), 64'(exp));
        chk({nm, " write_o"}, 64'(write_o), 64'd1);
        if (hold_cyc > 0) begin
            hold_i = 1'b1;
            for (int i = 0; i < hold_cyc; i++) begin
                @(posedge clk); #1;
                chk({nm, " held result"}, 64'(regw_data), 64'(exp));
                chk({nm, " held stall"}, 64'(stall_ex), 64'd0);
            end
            hold_i = 1'b0;
        end
        alusel = 3'b000; aluop = 3'd0; write_i = 1'b0;
        @(posedge clk); #1;
        chk({nm, " idle after done"}, 64'(stall_ex), 64'd0);
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{3'b100, 3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{3'b100, 3'd1, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFE, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[2]  = '{3'b100, 3'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[3]  = '{3'b100, 3'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[4]  = '{3'b001, 3'd0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'hFFF0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[5]  = '{3'b001, 3'd1, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'h00F0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[6]  = '{3'b001, 3'd2, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'hFF00, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[7]  = '{3'b001, 3'd3, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[8]  = '{3'b010, 3'd0, 32'd1, 32'h24, 32'd0, 32'd0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[9]  = '{3'b010, 3'd1, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'h08000000, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[10] = '{3'b010, 3'd2, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'hF8000000, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[11] = '{3'b110, 3'd0, 32'd3, 32'd4, 32'h1000, 32'd0, 32'h1000, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[12] = '{3'b111, 3'd0, 32'h100, 32'd0, 32'd0, 32'hFFFFFFFC, 32'hFC, 32'd0, 1'b1, 1'b0, 1'b1, 3'd1};
        vecs[13] = '{3'b111, 3'd4, 32'h200, 32'd0, 32'd0, 32'd6, 32'h206, 32'd0, 1'b1, 1'b0, 1'b0, 3'd2};
        vecs[14] = '{3'b111, 3'd2, 32'h10, 32'd0, 32'd0, 32'd4, 32'h14, 32'd0, 1'b1, 1'b0, 1'b0, 3'd4};
        vecs[15] = '{3'b111, 3'd7, 32'h300, 32'hDEAD, 32'd0, 32'd8, 32'h308, 32'hDEAD, 1'b0, 1'b1, 1'b0, 3'd4};
        vecs[16] = '{3'b100, 3'd5, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0};

        reset = 1'b1; flush = 1'b0; hold_i = 1'b0; write_i = 1'b1;
        alusel = 3'b100; aluop = 3'd0; op1 = 32'd5; op2 = 32'd7;
        link_addr = 32'd0; mem_offset = 32'd0; regw_addr_i = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("reset regw_data", 64'(regw_data), 64'd0);
        chk("reset write_o", 64'(write_o), 64'd0);
        chk("reset regw_addr_o", 64'(regw_addr_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            alusel = vecs[i].sel; aluop = vecs[i].op; op1 = vecs[i].a; op2 = vecs[i].b;
            link_addr = vecs[i].link; mem_offset = vecs[i].off; write_i = 1'b1;
            regw_addr_i = 5'(i);
            #2;
            chk($sformatf("vec%0d data", i), 64'(regw_data), 64'(vecs[i].data));
            chk($sformatf("vec%0d stall", i), 64'(stall_ex), 64'd0);
            chk($sformatf("vec%0d write_o", i), 64'(write_o), 64'd1);
            chk($sformatf("vec%0d addr", i), 64'(regw_addr_o), 64'(i));
            chk($sformatf("vec%0d memflags", i), {59'd0, load, store, mem_signed, 1'b0, 1'b0},
                {59'd0, vecs[i].ld, vecs[i].st, vecs[i].sg, 1'b0, 1'b0});
            chk($sformatf("vec%0d len", i), 64'(mem_length), 64'(vecs[i].len));
            chk($sformatf("vec%0d wdata", i), 64'(mem_write_data), 64'(vecs[i].wdata));
        end

        run_md("DIV -7/2",      3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
        run_md("REM -7/2",      3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
        run_md("REM 7/-2",      3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33, 0);
        run_md("DIV 7/-2",      3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
        run_md("DIVU x/0",      3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 2, 0);
        run_md("REMU x/0",      3'd7, 32'h1234, 32'd0, 32'h1234, 2, 0);
        run_md("DIV -5/0",      3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 2, 0);
        run_md("REM -5/0",      3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 2, 0);
        run_md("DIV ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 0);
        run_md("REM ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2, 0);
        run_md("MULH min*min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
        run_md("MULHSU -1*max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
        run_md("MULHU max*max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
        run_md("MUL 3*-4",      3'd0, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFF4, 33, 0);
        run_md("MUL 3*-4 again",3'd0, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFF4, 33, 0);
        run_md("DIVU hold",     3'd5, 32'd100, 32'd7, 32'd14, 33, 3);
        run_md("REMU 100/7",    3'd7, 32'd100, 32'd7, 32'd2, 33, 0);

        // Flush in the middle of a DIVU
        @(negedge clk);
        alusel = 3'b011; aluop = 3'd5; op1 = 32'd100; op2 = 32'd7; write_i = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        chk("flush pre-stall", 64'(stall_ex), 64'd1);
        flush = 1'b1; alusel = 3'b000; write_i = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush to idle", 64'(stall_ex), 64'd0);
        begin
            int bad = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (write_o || stall_ex) bad++;
            end
            chk("flush no write/stall", 64'(bad), 64'd0);
        end
        run_md("DIVU after flush", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);

        // Reset in the middle of a DIVU
        @(negedge clk);
        alusel = 3'b011; aluop = 3'd5; op1 = 32'd100; op2 = 32'd7; write_i = 1'b1;
        regw_addr_i = 5'd9;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset stall", 64'(stall_ex), 64'd0);
        chk("midreset outputs", {regw_data, 27'd0, regw_addr_o}, 64'd0);
        chk("midreset write_o", 64'(write_o), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; alusel = 3'b000; write_i = 1'b0;
        @(posedge clk); #1;
        chk("post reset idle", 64'(stall_ex), 64'd0);
        run_md("REMU after reset", 3'd7, 32'd100, 32'd7, 32'd2, 33, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
